cadder_sweep_ctrl: RTL and testbench

//  On-chip sequencer for the carry-adder (cadder) test harness; replaces the APG for exhaustive sweeps.

---
 rtl/cadder_pkg.sv | 25 ++
 rtl/cadder_err_logger.sv | 49 ++++
 rtl/cadder_sweep_ctrl.sv | 131 +++++++++++++
 tb/tb_cadder_sweep_ctrl.sv | 394 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cadder_pkg.sv
// Shared types and the golden adder reference for the cadder sweep sequencer.
package cadder_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        SETTLE,
        CHECK,
        DONE
    } sweep_state_e;

    localparam int CADDER_WIDTH = 4;

    // Reference sum is computed at a fixed wide width; callers zero-extend
    // their operands so any WIDTH up to GOLDEN_W shares one function.
    localparam int GOLDEN_W = 32;

    function automatic logic [GOLDEN_W:0] golden_sum(
        input logic [GOLDEN_W-1:0] a,
        input logic [GOLDEN_W-1:0] b
    );
        return {1'b0, a} + {1'b0, b};
    endfunction

endpackage

// File: rtl/cadder_err_logger.sv
// Saturating mismatch counter plus capture of the first failing vector of a sweep.
module cadder_err_logger
    import cadder_pkg::*;
#(
    parameter int WIDTH = CADDER_WIDTH,
    parameter int ERR_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             check_en,
    input  logic             mismatch,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [WIDTH:0]   dut_z,
    output logic [ERR_W-1:0] err_cnt,
    output logic             first_err_valid,
    output logic [WIDTH-1:0] first_err_a,
    output logic [WIDTH-1:0] first_err_b,
    output logic [WIDTH:0]   first_err_z
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt         <= '0;
            first_err_valid <= 1'b0;
            first_err_a     <= '0;
            first_err_b     <= '0;
            first_err_z     <= '0;
        end else if (clear) begin
            err_cnt         <= '0;
            first_err_valid <= 1'b0;
            first_err_a     <= '0;
            first_err_b     <= '0;
            first_err_z     <= '0;
        end else if (check_en && mismatch) begin
            if (err_cnt != '1) begin
                err_cnt <= err_cnt + 1'b1;
            end
            if (!first_err_valid) begin
                first_err_valid <= 1'b1;
                first_err_a     <= op_a;
                first_err_b     <= op_b;
                first_err_z     <= dut_z;
            end
        end
    end

endmodule

// File: rtl/cadder_sweep_ctrl.sv
// Exhaustive A/B operand sweep for the carry-adder harness: drive, settle, check, log.
module cadder_sweep_ctrl
    import cadder_pkg::*;
#(
    parameter int WIDTH    = CADDER_WIDTH,
    parameter int SETTLE_W = 8,
    parameter int ERR_W    = 16
) (
    input  logic                axi_clk,
    input  logic                axi_resetn,
    input  logic                start,
    input  logic                abort,
    input  logic [SETTLE_W-1:0] settle_cfg,
    input  logic [WIDTH:0]      dut_z,
    output logic [WIDTH-1:0]    op_a,
    output logic [WIDTH-1:0]    op_b,
    output logic                busy,
    output logic                done,
    output logic [2*WIDTH:0]    vec_cnt,
    output logic [ERR_W-1:0]    err_cnt,
    output logic                first_err_valid,
    output logic [WIDTH-1:0]    first_err_a,
    output logic [WIDTH-1:0]    first_err_b,
    output logic [WIDTH:0]      first_err_z
);

    sweep_state_e        state_reg;
    sweep_state_e        state_next;
    logic [SETTLE_W-1:0] settle_reg;
    logic [SETTLE_W-1:0] settle_cnt_reg;
    logic                start_sweep;
    logic                check_en;
    logic                mismatch;
    logic                last_vec;

    assign last_vec = (&op_a) & (&op_b);
    assign mismatch = golden_sum(GOLDEN_W'(op_a), GOLDEN_W'(op_b)) != (GOLDEN_W+1)'(dut_z);

    assign busy = (state_reg == DRIVE) || (state_reg == SETTLE) || (state_reg == CHECK);
    assign done = (state_reg == DONE);

    always_ff @(posedge axi_clk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // abort overrides every transition and suppresses the CHECK-cycle updates.
    always_comb begin
        state_next  = state_reg;
        start_sweep = 1'b0;
        check_en    = 1'b0;
        if (abort) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    if (start) begin
                        state_next  = DRIVE;
                        start_sweep = 1'b1;
                    end
                end
                DRIVE: begin
                    state_next = (settle_reg != '0) ? SETTLE : CHECK;
                end
                SETTLE: begin
                    if (settle_cnt_reg == SETTLE_W'(1)) begin
                        state_next = CHECK;
                    end
                end
                CHECK: begin
                    check_en   = 1'b1;
                    state_next = last_vec ? DONE : DRIVE;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge axi_clk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            op_a           <= '0;
            op_b           <= '0;
            vec_cnt        <= '0;
            settle_reg     <= '0;
            settle_cnt_reg <= '0;
        end else begin
            if (start_sweep) begin
                op_a       <= '0;
                op_b       <= '0;
                vec_cnt    <= '0;
                settle_reg <= settle_cfg;
            end else if (check_en) begin
                vec_cnt <= vec_cnt + 1'b1;
                op_b    <= op_b + 1'b1;
                if (&op_b) begin
                    op_a <= op_a + 1'b1;
                end
            end
            if (state_reg == DRIVE) begin
                settle_cnt_reg <= settle_reg;
            end else if (state_reg == SETTLE) begin
                settle_cnt_reg <= settle_cnt_reg - 1'b1;
            end
        end
    end

    cadder_err_logger #(
        .WIDTH (WIDTH),
        .ERR_W (ERR_W)
    ) u_err_logger (
        .clk             (axi_clk),
        .rst_n           (axi_resetn),
        .clear           (start_sweep),
        .check_en        (check_en),
        .mismatch        (mismatch),
        .op_a            (op_a),
        .op_b            (op_b),
        .dut_z           (dut_z),
        .err_cnt         (err_cnt),
        .first_err_valid (first_err_valid),
        .first_err_a     (first_err_a),
        .first_err_b     (first_err_b),
        .first_err_z     (first_err_z)
    );

endmodule

// File: tb/tb_cadder_sweep_ctrl.sv
// Scoreboard bench for cadder_sweep_ctrl: a behavioural adder model feeds dut_z, sweep results are queued and checked at done.
module tb_cadder_sweep_ctrl;

    logic       axi_clk = 1'b0;
    logic       axi_resetn = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] settle_cfg = 8'd0;
    logic [4:0] dut_z;
    logic [3:0] op_a, op_b, first_err_a, first_err_b;
    logic       busy, done, first_err_valid;
    logic [8:0] vec_cnt;
    logic [15:0] err_cnt;
    logic [4:0] first_err_z;

    // second instance with a narrow error counter for the saturation case
    logic       start2 = 1'b0;
    logic       abort2 = 1'b0;
    logic [7:0] settle2 = 8'd0;
    logic [4:0] dut_z2;
    logic [3:0] op_a2, op_b2, first_err_a2, first_err_b2;
    logic       busy2, done2, first_err_valid2;
    logic [8:0] vec_cnt2;
    logic [3:0] err_cnt2;
    logic [4:0] first_err_z2;

    int mode = 0;
    int cyc = 0;
    int errors = 0;
    int checks = 0;

    typedef struct {
        int lat;
        int vec;
        int err;
        int fev;
        int fa;
        int fb;
        int fz;
    } exp_t;

    exp_t exp_q[$];

    always #5 axi_clk = ~axi_clk;
    always @(posedge axi_clk) cyc <= cyc + 1;

    // mode 0: ideal adder, mode 1: carry-out stuck at 0, mode 2: LSB inverted (every vector fails)
    function automatic logic [4:0] model_z(input int m, input logic [3:0] a, input logic [3:0] b);
        logic [4:0] s;
        s = {1'b0, a} + {1'b0, b};
        case (m)
            1:       return {1'b0, s[3:0]};
            2:       return s ^ 5'd1;
            default: return s;
        endcase
    endfunction

    always_comb dut_z  = model_z(mode, op_a, op_b);
    always_comb dut_z2 = model_z(2, op_a2, op_b2);

    cadder_sweep_ctrl #(.WIDTH(4), .SETTLE_W(8), .ERR_W(16)) dut (
        .axi_clk         (axi_clk),
        .axi_resetn      (axi_resetn),
        .start           (start),
        .abort           (abort),
        .settle_cfg      (settle_cfg),
        .dut_z           (dut_z),
        .op_a            (op_a),
        .op_b            (op_b),
        .busy            (busy),
        .done            (done),
        .vec_cnt         (vec_cnt),
        .err_cnt         (err_cnt),
        .first_err_valid (first_err_valid),
        .first_err_a     (first_err_a),
        .first_err_b     (first_err_b),
        .first_err_z     (first_err_z)
    );

    cadder_sweep_ctrl #(.WIDTH(4), .SETTLE_W(8), .ERR_W(4)) dut_sat (
        .axi_clk         (axi_clk),
        .axi_resetn      (axi_resetn),
        .start           (start2),
        .abort           (abort2),
        .settle_cfg      (settle2),
        .dut_z           (dut_z2),
        .op_a            (op_a2),
        .op_b            (op_b2),
        .busy            (busy2),
        .done            (done2),
        .vec_cnt         (vec_cnt2),
        .err_cnt         (err_cnt2),
        .first_err_valid (first_err_valid2),
        .first_err_a     (first_err_a2),
        .first_err_b     (first_err_b2),
        .first_err_z     (first_err_z2)
    );

    function automatic exp_t build_expect(input int settle, input int m, input int err_max);
        exp_t e;
        logic [4:0] z;
        e.lat = 256 * (settle + 2);
        e.vec = 256;
        e.err = 0;
        e.fev = 0;
        e.fa  = 0;
        e.fb  = 0;
        e.fz  = 0;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                z = model_z(m, 4'(a), 4'(b));
                if (int'(z) != a + b) begin
                    if (e.err < err_max) e.err++;
                    if (e.fev == 0) begin
                        e.fev = 1;
                        e.fa  = a;
                        e.fb  = b;
                        e.fz  = int'(z);
                    end
                end
            end
        end
        return e;
    endfunction

    task automatic pulse_start(output int st_edge);
        @(negedge axi_clk);
        start = 1'b1;
        st_edge = cyc + 1;
        @(negedge axi_clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input int st, output int lat);
        lat = -1;
        for (int i = 0; i < budget; i++) begin
            if (done === 1'b1) begin
                lat = cyc - st;
                break;
            end
            @(negedge axi_clk);
        end
    endtask

    task automatic check_sweep(input string name, input int st);
        int lat;
        exp_t e;
        wait_done(3000, st, lat);
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s scoreboard: got empty queue, required one entry", name);
            return;
        end
        e = exp_q.pop_front();
        $display("sweep %s: lat=%0d vec=%0d err=%0d first=(%0d,%0d,%0d,%0d)",
                 name, lat, vec_cnt, err_cnt, first_err_valid, first_err_a, first_err_b, first_err_z);
        if (lat != e.lat) begin
            errors++;
            $display("FAIL %s latency: got %0d required %0d (-1 = timeout)", name, lat, e.lat);
        end
        checks++;
        if (vec_cnt !== 9'(e.vec)) begin
            errors++;
            $display("FAIL %s vec_cnt: got %0d required %0d", name, vec_cnt, e.vec);
        end
        checks++;
        if (err_cnt !== 16'(e.err)) begin
            errors++;
            $display("FAIL %s err_cnt: got %0d required %0d", name, err_cnt, e.err);
        end
        checks++;
        if (first_err_valid !== 1'(e.fev)) begin
            errors++;
            $display("FAIL %s first_err_valid: got %0d required %0d", name, first_err_valid, e.fev);
        end
        checks++;
        if (first_err_a !== 4'(e.fa) || first_err_b !== 4'(e.fb) || first_err_z !== 5'(e.fz)) begin
            errors++;
            $display("FAIL %s first_err: got (%0d,%0d,0x%0h) required (%0d,%0d,0x%0h)",
                     name, first_err_a, first_err_b, first_err_z, e.fa, e.fb, e.fz);
        end
        checks++;
        if (op_a !== 4'd0 || op_b !== 4'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s end_state: got op_a=%0d op_b=%0d busy=%0d required 0,0,0", name, op_a, op_b, busy);
        end
    endtask

    task automatic test_reset();
        axi_resetn = 1'b0;
        repeat (3) @(negedge axi_clk);
        checks++;
        if ({op_a, op_b, busy, done, vec_cnt, err_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_main: got op_a=%0d op_b=%0d busy=%0d done=%0d vec=%0d err=%0d required all 0",
                     op_a, op_b, busy, done, vec_cnt, err_cnt);
        end
        checks++;
        if ({first_err_valid, first_err_a, first_err_b, first_err_z} !== '0) begin
            errors++;
            $display("FAIL reset_first_err: got valid=%0d a=%0d b=%0d z=%0d required all 0",
                     first_err_valid, first_err_a, first_err_b, first_err_z);
        end
        axi_resetn = 1'b1;
        $display("reset: outputs sampled during reset");
    endtask

    task automatic test_ideal_sweep();
        int st;
        mode = 0;
        settle_cfg = 8'd0;
        exp_q.push_back(build_expect(0, 0, 65535));
        pulse_start(st);
        check_sweep("ideal_settle0", st);
        repeat (3) @(negedge axi_clk);
        checks++;
        if (done !== 1'b1 || vec_cnt !== 9'd256) begin
            errors++;
            $display("FAIL done_hold: got done=%0d vec=%0d required 1,256", done, vec_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int st;
        mode = 1;
        settle_cfg = 8'd3;
        exp_q.push_back(build_expect(3, 1, 65535));
        pulse_start(st);
        checks++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL restart_from_done: got done=%0d busy=%0d required 0,1", done, busy);
        end
        check_sweep("carry_stuck_settle3", st);
    endtask

    task automatic test_abort();
        int st;
        bit found;
        mode = 1;
        settle_cfg = 8'd0;
        pulse_start(st);
        found = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (op_a === 4'd5) begin
                found = 1'b1;
                break;
            end
            @(negedge axi_clk);
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL abort_reach_op_a5: got op_a=%0d required 5 within budget", op_a);
        end
        abort = 1'b1;
        start = 1'b1;
        @(negedge axi_clk);
        abort = 1'b0;
        start = 1'b0;
        $display("abort: issued with start at op_a=5, vec=%0d", vec_cnt);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || vec_cnt !== 9'd80 || op_a !== 4'd5) begin
            errors++;
            $display("FAIL abort_state: got busy=%0d done=%0d vec=%0d op_a=%0d required 0,0,80,5",
                     busy, done, vec_cnt, op_a);
        end
        checks++;
        if (err_cnt !== 16'd10 || first_err_valid !== 1'b1 || first_err_a !== 4'd1 || first_err_b !== 4'd15) begin
            errors++;
            $display("FAIL abort_partial_errs: got err=%0d valid=%0d a=%0d b=%0d required 10,1,1,15",
                     err_cnt, first_err_valid, first_err_a, first_err_b);
        end
        repeat (3) @(negedge axi_clk);
        checks++;
        if (busy !== 1'b0 || vec_cnt !== 9'd80) begin
            errors++;
            $display("FAIL abort_stays_idle: got busy=%0d vec=%0d required 0,80", busy, vec_cnt);
        end
        exp_q.push_back(build_expect(0, 1, 65535));
        pulse_start(st);
        checks++;
        if (vec_cnt !== 9'd0 || err_cnt !== 16'd0 || first_err_valid !== 1'b0 ||
            op_a !== 4'd0 || op_b !== 4'd0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_restart_clear: got vec=%0d err=%0d valid=%0d op_a=%0d op_b=%0d busy=%0d required 0,0,0,0,0,1",
                     vec_cnt, err_cnt, first_err_valid, op_a, op_b, busy);
        end
        check_sweep("after_abort", st);
    endtask

    task automatic test_restart_ignored();
        int st;
        mode = 0;
        settle_cfg = 8'd0;
        exp_q.push_back(build_expect(0, 0, 65535));
        pulse_start(st);
        repeat (100) @(negedge axi_clk);
        start = 1'b1;
        @(negedge axi_clk);
        start = 1'b0;
        $display("restart: start re-pulsed mid-sweep at vec=%0d", vec_cnt);
        check_sweep("restart_ignored", st);
    endtask

    task automatic test_saturation();
        exp_t e;
        exp_t sat_q[$];
        bit seen;
        sat_q.push_back(build_expect(0, 2, 15));
        @(negedge axi_clk);
        start2 = 1'b1;
        @(negedge axi_clk);
        start2 = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (done2 === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(negedge axi_clk);
        end
        e = sat_q.pop_front();
        $display("saturate: done=%0d vec=%0d err=%0d", done2, vec_cnt2, err_cnt2);
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL sat_done: got done2=%0d required 1 within budget", done2);
        end
        checks++;
        if (err_cnt2 !== 4'(e.err) || vec_cnt2 !== 9'(e.vec)) begin
            errors++;
            $display("FAIL sat_counts: got err=%0d vec=%0d required %0d,%0d", err_cnt2, vec_cnt2, e.err, e.vec);
        end
        checks++;
        if (first_err_valid2 !== 1'b1 || first_err_a2 !== 4'(e.fa) || first_err_b2 !== 4'(e.fb) ||
            first_err_z2 !== 5'(e.fz)) begin
            errors++;
            $display("FAIL sat_first_err: got (%0d,%0d,%0d,%0d) required (1,%0d,%0d,%0d)",
                     first_err_valid2, first_err_a2, first_err_b2, first_err_z2, e.fa, e.fb, e.fz);
        end
    endtask

    task automatic test_async_reset();
        int st;
        mode = 0;
        settle_cfg = 8'd5;
        pulse_start(st);
        // 7-cycle vectors: offset 143 lands in SETTLE of vector 20 (op_a=1, op_b=4)
        repeat (142) @(negedge axi_clk);
        checks++;
        if (busy !== 1'b1 || vec_cnt !== 9'd20 || op_a !== 4'd1 || op_b !== 4'd4) begin
            errors++;
            $display("FAIL pre_reset_state: got busy=%0d vec=%0d op_a=%0d op_b=%0d required 1,20,1,4",
                     busy, vec_cnt, op_a, op_b);
        end
        #2;
        axi_resetn = 1'b0;
        #1;
        $display("async_reset: asserted mid-SETTLE");
        checks++;
        if ({op_a, op_b, busy, done, vec_cnt, err_cnt, first_err_valid} !== '0) begin
            errors++;
            $display("FAIL async_reset_outputs: got op_a=%0d op_b=%0d busy=%0d done=%0d vec=%0d err=%0d valid=%0d required all 0",
                     op_a, op_b, busy, done, vec_cnt, err_cnt, first_err_valid);
        end
        @(negedge axi_clk);
        axi_resetn = 1'b1;
        settle_cfg = 8'd0;
        exp_q.push_back(build_expect(0, 0, 65535));
        pulse_start(st);
        check_sweep("post_reset", st);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_ideal_sweep();
        test_back_to_back();
        test_abort();
        test_restart_ignored();
        test_saturation();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
